// File: rtl/seq_div.sv
// Restoring sequential divider, one quotient bit per clock, MSB first.
// Define SEQ_DIV_SIGNED_EN for two's complement operands and results.
module seq_div #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             rdy,
   output logic             dbz
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] S_LOAD = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic [CW-1:0]    cnt;

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;
   logic             take;
   logic [WIDTH:0]   rem_nx;
   logic [WIDTH-1:0] quo_nx;
   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;
   logic [WIDTH-1:0] a_back;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   // Remainder stays below the divisor, so the top bit of diff is a borrow.
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      diff    = shifted - {2'b00, dvs};
      take    = ~diff[WIDTH+1];
      rem_nx  = take ? diff[WIDTH:0] : shifted[WIDTH:0];
      quo_nx  = {quo[WIDTH-2:0], take};
   end

`ifdef SEQ_DIV_SIGNED_EN
   logic neg_a;
   logic neg_b;

   always_comb begin
      a_mag  = a[WIDTH-1] ? -a : a;
      b_mag  = b[WIDTH-1] ? -b : b;
      q_fin  = (neg_a ^ neg_b) ? -quo_nx : quo_nx;
      r_fin  = neg_a ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
      a_back = neg_a ? -quo : quo;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         neg_a <= a[WIDTH-1];
         neg_b <= b[WIDTH-1];
      end
   end
`else
   always_comb begin
      a_mag  = a;
      b_mag  = b;
      q_fin  = quo_nx;
      r_fin  = rem_nx[WIDTH-1:0];
      a_back = quo;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_LOAD;
         rem   <= '0;
         quo   <= a_mag;
         dvs   <= b_mag;
         cnt   <= '0;
         q     <= '0;
         r     <= '0;
         rdy   <= 1'b0;
         dbz   <= 1'b0;
      end else begin
         unique case (state)
            S_LOAD: begin
               if (dvs == '0) begin
                  state <= S_DONE;
                  q     <= '1;
                  r     <= a_back;
                  rdy   <= 1'b1;
                  dbz   <= 1'b1;
               end else begin
                  state <= S_RUN;
                  rem   <= rem_nx;
                  quo   <= quo_nx;
                  cnt   <= cnt + CW'(1);
               end
            end
            S_RUN: begin
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= S_DONE;
                  q     <= q_fin;
                  r     <= r_fin;
                  rdy   <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_DONE;
            end
            default: begin
               state <= S_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (WIDTH=8): vectors, abort case, random.
// Honours SEQ_DIV_SIGNED_EN for the expected results.
module tb_seq_div;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [7:0] q;
   logic [7:0] r;
   logic       rdy;
   logic       dbz;

   int tests = 0;
   int fails = 0;

   seq_div #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b),
      .q(q), .r(r), .rdy(rdy), .dbz(dbz)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       dbz;
      int         lat;
   } vec_t;

   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Reference: plain integer division on the operands.
   function automatic void model(input logic [7:0] ia, input logic [7:0] ib,
                                 output logic [7:0] eq, output logic [7:0] er,
                                 output logic ed, output int el);
      int sa;
      int sb;
      int qq;
      int rr;
`ifdef SEQ_DIV_SIGNED_EN
      sa = int'($signed(ia));
      sb = int'($signed(ib));
`else
      sa = int'(ia);
      sb = int'(ib);
`endif
      if (sb == 0) begin
         eq = 8'hFF;
         er = ia;
         ed = 1'b1;
         el = 1;
      end else begin
         qq = sa / sb;
         rr = sa % sb;
         eq = qq[7:0];
         er = rr[7:0];
         ed = 1'b0;
         el = 8;
      end
   endfunction

   task automatic run_div(input logic [7:0] ia, input logic [7:0] ib,
                          output logic [7:0] oq, output logic [7:0] orr,
                          output logic odbz, output int lat);
      @(negedge clk);
      reset = 1'b1;
      a = ia;
      b = ib;
      @(posedge clk);
      #1;
      check("reset_rdy", int'(rdy), 0);
      check("reset_q", int'(q), 0);
      check("reset_r", int'(r), 0);
      check("reset_dbz", int'(dbz), 0);
      @(negedge clk);
      reset = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (rdy) break;
      end
      check("rdy_seen", int'(rdy), 1);
      oq = q;
      orr = r;
      odbz = dbz;
      @(posedge clk);
      #1;
      check("hold_rdy", int'(rdy), 1);
      check("hold_q", int'(q), int'(oq));
      check("hold_r", int'(r), int'(orr));
   endtask

   task automatic do_vec(input string name, input logic [7:0] ia,
                         input logic [7:0] ib, input logic [7:0] eq,
                         input logic [7:0] er, input logic ed,
                         input int el);
      logic [7:0] gq;
      logic [7:0] gr;
      logic       gd;
      int         gl;
      run_div(ia, ib, gq, gr, gd, gl);
      check({name, "_q"}, int'(gq), int'(eq));
      check({name, "_r"}, int'(gr), int'(er));
      check({name, "_dbz"}, int'(gd), int'(ed));
      check({name, "_lat"}, gl, el);
   endtask

   vec_t vecs[$];

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [7:0] eq;
      logic [7:0] er;
      logic       ed;
      int         el;
      logic [7:0] gq;
      logic [7:0] gr;
      logic       gd;
      int         gl;

      vecs.push_back('{8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8});
      vecs.push_back('{8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1});
      vecs.push_back('{8'd0, 8'd0, 8'hFF, 8'd0, 1'b1, 1});
      vecs.push_back('{8'd1, 8'd1, 8'd1, 8'd0, 1'b0, 8});
`ifdef SEQ_DIV_SIGNED_EN
      vecs.push_back('{8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 8});
      vecs.push_back('{8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, 8});
      vecs.push_back('{8'd0, 8'hFD, 8'd0, 8'd0, 1'b0, 8});
      vecs.push_back('{8'd100, 8'hF9, 8'hF2, 8'd2, 1'b0, 8});
      vecs.push_back('{8'h80, 8'd0, 8'hFF, 8'h80, 1'b1, 1});
      vecs.push_back('{8'h7F, 8'h80, 8'd0, 8'h7F, 1'b0, 8});
`else
      vecs.push_back('{8'h9C, 8'd7, 8'd22, 8'd2, 1'b0, 8});
      vecs.push_back('{8'hFF, 8'd1, 8'hFF, 8'd0, 1'b0, 8});
      vecs.push_back('{8'hFF, 8'hFF, 8'd1, 8'd0, 8'd0 != 0, 8});
      vecs.push_back('{8'd6, 8'hFF, 8'd0, 8'd6, 1'b0, 8});
      vecs.push_back('{8'hFE, 8'd2, 8'h7F, 8'd0, 1'b0, 8});
`endif

      for (int i = 0; i < vecs.size(); i++)
         do_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat);

      // Abort a running division and restart with new operands.
      @(negedge clk);
      reset = 1'b1;
      a = 8'd200;
      b = 8'd3;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("abort_rdy_low", int'(rdy), 0);
      end
      do_vec("abort_restart", 8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 8);

      for (int n = 0; n < 1000; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom_range(1, 255));
         model(ra, rb, eq, er, ed, el);
         run_div(ra, rb, gq, gr, gd, gl);
         check("rand_q", int'(gq), int'(eq));
         check("rand_r", int'(gr), int'(er));
         check("rand_dbz", int'(gd), int'(ed));
         check("rand_lat", gl, el);
`ifndef SEQ_DIV_SIGNED_EN
         check("rand_inv", int'(gq) * int'(rb) + int'(gr), int'(ra));
         check("rand_rlt", int'(gr < rb), 1);
`endif
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
